mode_select_ctrl: RTL and testbench

//   Consumes debounced push-button levels and selects the active filter mode
//   (pass-through, Gaussian, oriented Sobel variants) for the edge-detection pipeline.

---
 rtl/mode_select_ctrl.sv | 125 ++++++++++++
 tb/tb_mode_select_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mode_select_ctrl.sv
// Filter-mode selector: button edge detection, wrap-around pending mode, long-press
// return to default, and frame-aligned commit of the active mode.
module mode_select_ctrl #(
    parameter int NUM_MODES    = 6,
    parameter int MODE_W       = 3,
    parameter int DEFAULT_MODE = 0,
    parameter int LONG_PRESS   = 100_000_000,
    parameter int CNT_W        = 27
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_btn_next,
    input  logic              i_btn_prev,
    input  logic              i_frame_start,
    output logic [MODE_W-1:0] o_mode,
    output logic              o_mode_pending,
    output logic              o_mode_changed,
    output logic              o_long_press
);

    localparam logic [MODE_W-1:0] MODE_DEF  = MODE_W'(DEFAULT_MODE);
    localparam logic [MODE_W-1:0] MODE_MAX  = MODE_W'(NUM_MODES - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(LONG_PRESS - 1);
    localparam logic [CNT_W-1:0]  HOLD_TOP  = CNT_W'(LONG_PRESS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        LATCHED = 2'd2
    } state_t;

    function automatic logic [MODE_W-1:0] step_up(input logic [MODE_W-1:0] m);
        return (m == MODE_MAX) ? '0 : m + MODE_W'(1);
    endfunction

    function automatic logic [MODE_W-1:0] step_down(input logic [MODE_W-1:0] m);
        return (m == '0) ? MODE_MAX : m - MODE_W'(1);
    endfunction

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              btn_next_q;
    logic              btn_prev_q;
    logic [MODE_W-1:0] pend_q;
    logic              rise_next;
    logic              rise_prev;
    logic              long_evt;

    assign rise_next = i_btn_next & ~btn_next_q;
    assign rise_prev = i_btn_prev & ~btn_prev_q;

    // The long press fires on the edge that brings the counter to LONG_PRESS.
    assign long_evt = (state == HOLD) && i_btn_next && (cnt == HOLD_LAST);

    assign o_mode_pending = (pend_q != o_mode);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            o_long_press <= 1'b0;
        end else begin
            o_long_press <= long_evt;
            case (state)
                IDLE: begin
                    if (rise_next) begin
                        state <= HOLD;
                        cnt   <= CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (!i_btn_next) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (long_evt) begin
                        state <= LATCHED;
                        cnt   <= HOLD_TOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                LATCHED: begin
                    if (!i_btn_next) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Commit samples pend_q before this cycle's button update lands in it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            btn_next_q     <= 1'b0;
            btn_prev_q     <= 1'b0;
            pend_q         <= MODE_DEF;
            o_mode         <= MODE_DEF;
            o_mode_changed <= 1'b0;
        end else begin
            btn_next_q <= i_btn_next;
            btn_prev_q <= i_btn_prev;

            if (long_evt) begin
                pend_q <= MODE_DEF;
            end else if (rise_next && !rise_prev) begin
                pend_q <= step_up(pend_q);
            end else if (rise_prev && !rise_next) begin
                pend_q <= step_down(pend_q);
            end

            if (i_frame_start && (pend_q != o_mode)) begin
                o_mode         <= pend_q;
                o_mode_changed <= 1'b1;
            end else begin
                o_mode_changed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mode_select_ctrl.sv
// Directed bench for mode_select_ctrl: a vector table for the stepping/commit cases
// plus hand-written long-press and mid-hold reset sequences.
module tb_mode_select_ctrl;

    logic       clk;
    logic       rst_n;
    logic       btn_next;
    logic       btn_prev;
    logic       frame_start;
    logic [2:0] mode;
    logic       mode_pending;
    logic       mode_changed;
    logic       long_press;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic       n;
        logic       p;
        logic       f;
        logic [2:0] mode;
        logic       pend;
        logic       chg;
        logic       lp;
    } vec_t;

    vec_t vecs[$];

    mode_select_ctrl #(
        .NUM_MODES   (6),
        .MODE_W      (3),
        .DEFAULT_MODE(0),
        .LONG_PRESS  (16),
        .CNT_W       (5)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_btn_next    (btn_next),
        .i_btn_prev    (btn_prev),
        .i_frame_start (frame_start),
        .o_mode        (mode),
        .o_mode_pending(mode_pending),
        .o_mode_changed(mode_changed),
        .o_long_press  (long_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int m, input int pd, input int c, input int l);
        chk({tag, " mode"}, int'(mode), m);
        chk({tag, " pending"}, int'(mode_pending), pd);
        chk({tag, " changed"}, int'(mode_changed), c);
        chk({tag, " long_press"}, int'(long_press), l);
    endtask

    task automatic add(input logic n, input logic p, input logic f, input logic [2:0] m,
                       input logic pd, input logic c, input logic l);
        vec_t v;
        v.n = n; v.p = p; v.f = f; v.mode = m; v.pend = pd; v.chg = c; v.lp = l;
        vecs.push_back(v);
    endtask

    initial begin
        int lp_count;

        // Three 4-cycle next presses, then commit 0 -> 3
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) add(1, 0, 0, 0, 1, 0, 0);
            add(0, 0, 0, 0, 1, 0, 0);
        end
        add(0, 0, 1, 3, 0, 1, 0);
        add(0, 0, 0, 3, 0, 0, 0);
        // Up to 5, wrap up to 0, wrap down to 5
        add(1, 0, 0, 3, 1, 0, 0); add(0, 0, 0, 3, 1, 0, 0);
        add(1, 0, 0, 3, 1, 0, 0); add(0, 0, 0, 3, 1, 0, 0);
        add(0, 0, 1, 5, 0, 1, 0); add(0, 0, 0, 5, 0, 0, 0);
        add(1, 0, 0, 5, 1, 0, 0); add(0, 0, 0, 5, 1, 0, 0);
        add(0, 0, 1, 0, 0, 1, 0); add(0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0); add(0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 5, 0, 1, 0); add(0, 0, 0, 5, 0, 0, 0);
        // Simultaneous rises are ignored
        add(1, 1, 0, 5, 0, 0, 0); add(0, 0, 0, 5, 0, 0, 0);
        // Next press coinciding with frame start: old pend (4) commits, new (5) next frame
        add(0, 1, 0, 5, 1, 0, 0); add(0, 0, 0, 5, 1, 0, 0);
        add(1, 0, 1, 4, 1, 1, 0); add(0, 0, 0, 4, 1, 0, 0);
        add(0, 0, 1, 5, 0, 1, 0); add(0, 0, 0, 5, 0, 0, 0);
        // Frame start with nothing pending
        add(0, 0, 1, 5, 0, 0, 0); add(0, 0, 0, 5, 0, 0, 0);
        // Step to 2 (5 -> 0 -> 1 -> 2) and commit
        for (int r = 0; r < 3; r++) begin
            add(1, 0, 0, 5, 1, 0, 0);
            add(0, 0, 0, 5, 1, 0, 0);
        end
        add(0, 0, 1, 2, 0, 1, 0);
        add(0, 0, 0, 2, 0, 0, 0);

        rst_n       = 1'b0;
        btn_next    = 1'b0;
        btn_prev    = 1'b0;
        frame_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_all("reset", 0, 0, 0, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            btn_next    = vecs[i].n;
            btn_prev    = vecs[i].p;
            frame_start = vecs[i].f;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].mode, vecs[i].pend, vecs[i].chg, vecs[i].lp);
        end
        btn_next = 1'b0; btn_prev = 1'b0; frame_start = 1'b0;

        // Long press from pending 2; commit 3 at hold cycle 5 to observe the short-press step
        lp_count = 0;
        btn_next = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            frame_start = (k == 5);
            step();
            frame_start = 1'b0;
            if (long_press) lp_count++;
            chk_all($sformatf("hold%0d", k), (k < 5) ? 2 : 3,
                    (k < 5 || k >= 16) ? 1 : 0, (k == 5) ? 1 : 0, (k == 16) ? 1 : 0);
        end
        chk("long_press pulse count", lp_count, 1);
        btn_next = 1'b0;
        step();
        chk_all("hold release", 3, 1, 0, 0);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk_all("commit default", 0, 0, 1, 0);

        // Reach mode 4, then reset mid-hold at counter 10
        btn_prev = 1'b1; step(); btn_prev = 1'b0; step();
        btn_prev = 1'b1; step(); btn_prev = 1'b0; step();
        frame_start = 1'b1; step(); frame_start = 1'b0;
        step();
        chk_all("setup mode4", 4, 0, 0, 0);
        btn_next = 1'b1;
        for (int k = 1; k <= 10; k++) step();
        chk_all("hold cnt10", 4, 1, 0, 0);
        rst_n = 1'b0;
        #1;
        chk_all("async reset", 0, 0, 0, 0);
        step();
        step();
        chk_all("in reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        lp_count = 0;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (long_press) lp_count++;
        end
        chk("no long_press after reset", lp_count, 0);
        chk("mode after reset hold", int'(mode), 0);
        btn_next = 1'b0;
        step();
        btn_next = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k >= 14) chk($sformatf("repress long%0d", k), int'(long_press), (k == 16) ? 1 : 0);
        end
        btn_next = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
